// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [31:0] MEM_TOP_DEFAULT = 32'h0001FFFF;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last-grant flips only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    logic last;

    // last=1 means requester 1 won most recently, so requester 0 wins a tie
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (take && (gnt != 2'b00))
            last <= gnt[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core and DMA word accesses onto one data memory port,
// one transaction at a time: IDLE (grant) -> ACCESS (memory) -> RESP (pulse).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP = ADDRESS_WIDTH'(MEM_TOP_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr0,
    input  logic [ADDRESS_WIDTH-1:0] req_addr1,
    input  logic [WORD_WIDTH-1:0]    req_wdata0,
    input  logic [WORD_WIDTH-1:0]    req_wdata1,
    output logic [1:0]               resp_valid,
    output logic                     resp_err,
    output logic [WORD_WIDTH-1:0]    resp_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [WORD_WIDTH-1:0]    mem_WD,
    output logic                     mem_WE,
    input  logic [WORD_WIDTH-1:0]    mem_RD
);
    state_t                   state;
    logic [1:0]               gnt;
    logic                     sel;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0]    sel_wdata;
    logic                     in_range;
    logic                     hs;
    logic                     owner;
    logic                     we_q;
    logic                     err_q;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req_valid),
        .take (state == IDLE),
        .gnt  (gnt)
    );

    assign req_ready = (state == IDLE) ? gnt : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign sel       = gnt[1];
    assign sel_we    = req_we[sel];
    assign sel_addr  = sel ? req_addr1  : req_addr0;
    assign sel_wdata = sel ? req_wdata1 : req_wdata0;

    // One extra bit so addresses near the top of the space cannot wrap into range
    assign in_range = ({1'b0, sel_addr} + (ADDRESS_WIDTH+1)'(3)) <= {1'b0, MEM_TOP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            resp_valid <= 2'b00;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_A      <= '0;
            mem_WD     <= '0;
            mem_WE     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state  <= ACCESS;
                        owner  <= sel;
                        we_q   <= sel_we;
                        err_q  <= !in_range;
                        mem_A  <= sel_addr;
                        mem_WD <= sel_wdata;
                        mem_WE <= sel_we && in_range;
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    mem_WE     <= 1'b0;
                    resp_rdata <= (!we_q && !err_q) ? mem_RD : '0;
                    resp_err   <= err_q;
                    resp_valid <= owner ? 2'b10 : 2'b01;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
